// File: rtl/regbank_write_sched.sv
// Write-port scheduler for the 8-entry register bank: zero-fills the bank after
// reset/clear, then round-robin arbitrates N requesters onto one sel/wd/we port.
module regbank_write_sched #(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic [N-1:0]   req_valid,
  input  logic [3*N-1:0] req_sel,
  input  logic [W*N-1:0] req_wd,
  output logic [N-1:0]   req_ready,
  output logic [2:0]     sel,
  output logic [W-1:0]   wd,
  output logic           we,
  output logic           init_done,
  output logic [7:0]     stall_cnt
);

  typedef enum logic {INIT, ARB} state_t;

  localparam logic [2:0] LAST = 3'(N - 1);

  state_t       state, state_nxt;
  logic [2:0]   cnt;
  logic [2:0]   rr_ptr;
  logic [2:0]   rr_nxt;
  logic         gnt_any;
  logic         hit_hi;
  logic [2:0]   gnt_idx;
  logic [2:0]   gnt_sel;
  logic [W-1:0] gnt_wd;
  logic [3:0]   pc;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= INIT;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (clear)                          state_nxt = INIT;
    else if (state == INIT && cnt == 3'd7) state_nxt = ARB;
  end

  // Grant logic: lowest valid index at or above rr_ptr wins, else lowest valid
  // overall, which equals a circular scan starting at rr_ptr.
  always_comb begin
    req_ready = '0;
    gnt_any   = 1'b0;
    hit_hi    = 1'b0;
    gnt_idx   = '0;
    gnt_sel   = '0;
    gnt_wd    = '0;
    pc        = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pc = pc + 4'(req_valid[i]);
    end
    if (state == ARB && !clear) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!hit_hi && req_valid[i] && 3'(i) >= rr_ptr) begin
          hit_hi  = 1'b1;
          gnt_any = 1'b1;
          gnt_idx = 3'(i);
          gnt_sel = req_sel[3*i +: 3];
          gnt_wd  = req_wd[W*i +: W];
        end
      end
      for (int unsigned i = 0; i < N; i++) begin
        if (!gnt_any && req_valid[i]) begin
          gnt_any = 1'b1;
          gnt_idx = 3'(i);
          gnt_sel = req_sel[3*i +: 3];
          gnt_wd  = req_wd[W*i +: W];
        end
      end
      if (gnt_any) req_ready[gnt_idx] = 1'b1;
    end
    rr_nxt = (gnt_idx == LAST) ? 3'd0 : gnt_idx + 3'd1;
  end

  // Registered outputs, init counter, pointer and stall counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      rr_ptr    <= '0;
      sel       <= '0;
      wd        <= '0;
      we        <= 1'b0;
      init_done <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (state == ARB && pc >= 4'd2 && stall_cnt != 8'hFF)
        stall_cnt <= stall_cnt + 8'd1;
      if (clear) begin
        cnt       <= '0;
        init_done <= 1'b0;
        we        <= 1'b0;
      end else if (state == INIT) begin
        sel <= cnt;
        wd  <= '0;
        we  <= 1'b1;
        cnt <= cnt + 3'd1;
        if (cnt == 3'd7) init_done <= 1'b1;
      end else if (gnt_any) begin
        sel    <= gnt_sel;
        wd     <= gnt_wd;
        we     <= 1'b1;
        rr_ptr <= rr_nxt;
      end else begin
        we <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regbank_write_sched.sv
// Self-checking bench for regbank_write_sched: directed scenarios plus random
// traffic compared cycle by cycle against a behavioural scheduler model.
module tb_regbank_write_sched;
  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           clear;
  logic [N-1:0]   req_valid;
  logic [3*N-1:0] req_sel;
  logic [W*N-1:0] req_wd;
  logic [N-1:0]   req_ready;
  logic [2:0]     sel;
  logic [W-1:0]   wd;
  logic           we;
  logic           init_done;
  logic [7:0]     stall_cnt;

  regbank_write_sched #(.W(W), .N(N)) dut (
    .clk(clk), .rst(rst), .clear(clear), .req_valid(req_valid),
    .req_sel(req_sel), .req_wd(req_wd), .req_ready(req_ready),
    .sel(sel), .wd(wd), .we(we), .init_done(init_done), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Behavioural model state
  bit m_arb;
  int m_cnt, m_ptr, m_sel, m_wd, m_we, m_done, m_stall;
  int last_g;
  logic [W-1:0] bank [8];   // bank as driven by the DUT outputs
  logic [W-1:0] mbank [8];  // bank as driven by the model

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_arb = 0; m_cnt = 0; m_ptr = 0; m_sel = 0; m_wd = 0;
    m_we = 0; m_done = 0; m_stall = 0; last_g = -1;
  endtask

  function automatic int model_grant();
    if (!m_arb || clear) return -1;
    for (int k = 0; k < N; k++) begin
      int idx = (m_ptr + k) % N;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_edge(input int g);
    if (m_arb && $countones(req_valid) >= 2 && m_stall < 255) m_stall++;
    if (clear) begin
      m_arb = 0; m_cnt = 0; m_done = 0; m_we = 0;
    end else if (!m_arb) begin
      m_sel = m_cnt; m_wd = 0; m_we = 1;
      if (m_cnt == 7) begin m_arb = 1; m_done = 1; end
      m_cnt = (m_cnt + 1) % 8;
    end else if (g >= 0) begin
      m_sel = int'(req_sel[3*g +: 3]);
      m_wd  = int'(req_wd[W*g +: W]);
      m_we  = 1;
      m_ptr = (g + 1) % N;
    end else begin
      m_we = 0;
    end
  endtask

  // One clock cycle: compare everything, advance across the rising edge.
  task automatic step();
    int g;
    logic [N-1:0] er;
    logic [2:0] dsel;
    logic [W-1:0] dwd;
    logic dwe;
    #1;
    g = model_grant();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("sel", 32'(sel), m_sel);
    chk("wd", 32'(wd), m_wd);
    chk("we", 32'(we), m_we);
    chk("init_done", 32'(init_done), m_done);
    chk("stall_cnt", 32'(stall_cnt), m_stall);
    dsel = sel; dwd = wd; dwe = we;
    @(posedge clk);
    if (dwe) bank[dsel] = dwd;
    if (m_we != 0) mbank[m_sel] = W'(m_wd);
    model_edge(g);
    last_g = g;
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input int s, input int d);
    req_sel[3*i +: 3] = 3'(s);
    req_wd[W*i +: W]  = W'(d);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1 model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_init();
    for (int k = 0; k < 8; k++) begin
      step();
      chk("init_sel", 32'(sel), k);
      chk("init_we", 32'(we), 1);
      chk("init_wd", 32'(wd), 0);
    end
    chk("init_done_rise", 32'(init_done), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; clear = 1'b0; req_valid = '0; req_sel = '0; req_wd = '0;
    for (int r = 0; r < 8; r++) begin bank[r] = 8'hFF; mbank[r] = 8'hFF; end
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_we", 32'(we), 0);
    chk("rst_init_done", 32'(init_done), 0);
    chk("rst_stall", 32'(stall_cnt), 0);
    chk("rst_ready", 32'(req_ready), 0);
    rst = 1'b0;

    // Reset release, no requests
    run_init();
    step();
    chk("post_init_we", 32'(we), 0);
    for (int r = 0; r < 8; r++) chk("bank_zero", 32'(bank[r]), 0);

    // Requester 2 alone
    req_valid = 4'b0100; set_req(2, 5, 8'hA5);
    #1 chk("r2_ready", 32'(req_ready), 32'b0100);
    step();
    chk("r2_sel", 32'(sel), 5);
    chk("r2_wd", 32'(wd), 32'hA5);
    chk("r2_we", 32'(we), 1);
    req_valid = '0;
    step();
    chk("r2_bank5", 32'(bank[5]), 32'hA5);

    // All four valid continuously; stall counter saturation
    do_reset();
    run_init();
    for (int i = 0; i < N; i++) set_req(i, i, i + 1);
    req_valid = '1;
    for (int k = 0; k < 260; k++) begin
      #1 chk("rr_order", 32'(req_ready), 32'(1 << (k % 4)));
      step();
      chk("stall_sat", 32'(stall_cnt), (k + 1 > 255) ? 255 : k + 1);
    end
    req_valid = '0;
    step();
    for (int i = 0; i < N; i++) chk("all4_bank", 32'(bank[i]), i + 1);

    // Collision on register 4, rr_ptr back at 0
    req_valid = 4'b1010; set_req(1, 4, 11); set_req(3, 4, 33);
    #1 chk("coll_first", 32'(req_ready), 32'b0010);
    step();
    req_valid = 4'b1000;
    #1 chk("coll_second", 32'(req_ready), 32'b1000);
    step();
    req_valid = '0;
    step();
    chk("coll_bank4", 32'(bank[4]), 33);

    // Clear pulse while requester 0 is valid
    req_valid = 4'b0001; set_req(0, 6, 8'h5A); clear = 1'b1;
    #1 chk("clr_ready", 32'(req_ready), 0);
    step();
    clear = 1'b0;
    chk("clr_init_done", 32'(init_done), 0);
    chk("clr_we", 32'(we), 0);
    run_init();
    #1 chk("clr_regrant", 32'(req_ready), 32'b0001);
    step();
    chk("clr_regrant_sel", 32'(sel), 6);
    chk("clr_regrant_wd", 32'(wd), 32'h5A);
    req_valid = '0;
    step();

    // Asynchronous reset mid-INIT at cnt=4
    do_reset();
    for (int k = 0; k < 4; k++) step();
    chk("mid_sel3", 32'(sel), 3);
    #2 rst = 1'b1;
    #1;
    chk("async_sel", 32'(sel), 0);
    chk("async_we", 32'(we), 0);
    chk("async_done", 32'(init_done), 0);
    chk("async_stall", 32'(stall_cnt), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    run_init();

    // Randomized traffic with requester-side handshake rules
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && last_g != i) begin
          if ($urandom_range(7) == 0) req_valid[i] = 1'b0;
        end else begin
          req_valid[i] = ($urandom_range(2) != 0);
          set_req(i, $urandom_range(7), $urandom_range(255));
        end
      end
      clear = ($urandom_range(59) == 0);
      step();
    end
    clear = 1'b0; req_valid = '0;
    step(); step();
    for (int r = 0; r < 8; r++) chk("rand_bank", 32'(bank[r]), 32'(mbank[r]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/regbank_write_sched.md
# regbank_write_sched

Write-port scheduler for the 8-entry register bank driven by the 3-to-8 select decoder. It clears all eight registers after reset, then shares the single write port among N requesters. Arbitration is round-robin with a valid/ready handshake. It drives the bank's `sel`/`wd` inputs plus a write strobe `we`, which gates the decoder outputs onto the per-register write enables.

## Interface
- `W`, default 8: data width; equals the bank register width.
- `N`, default 4: number of requesters, 2..8.
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `clear`, input, 1: synchronous request to re-run the zero-initialisation sequence.
- `req_valid`, input, N: per-requester write request.
- `req_sel`, input, 3*N: target register index; requester i uses bits [3i+2:3i].
- `req_wd`, input, W*N: write data; requester i uses bits [Wi+W-1:Wi].
- `req_ready`, output, N: one-hot grant, combinational; a transfer occurs when `req_valid[i] & req_ready[i]`.
- `sel`, output, 3: registered register index to the decoder.
- `wd`, output, W: registered write data to the bank.
- `we`, output, 1: registered write strobe; the bank writes only when it is 1.
- `init_done`, output, 1: high when the bank is initialised and arbitration is active.
- `stall_cnt`, output, 8: saturating count of arbitration cycles with at least one losing requester.

## Operation
- FSM states: INIT and ARB.
- `rst` forces state INIT, init counter `cnt`=0, round-robin pointer `rr_ptr`=0, and clears all outputs.
- INIT:
  - Each cycle registers `sel`=`cnt`, `wd`=0, `we`=1, then increments `cnt`.
  - `req_ready` is all 0.
  - After registering `cnt`=7, the next state is ARB and `init_done` registers to 1 on the same edge.
- ARB, grant selection:
  - The grant goes to the first i with `req_valid[i]`=1, searching i = `rr_ptr`, `rr_ptr`+1, … mod N.
  - `req_ready[i]`=1 for that i only.
- ARB, on a grant:
  - `sel`/`wd` register the granted requester's fields and `we` registers 1.
  - `rr_ptr` becomes (i+1) mod N.
- ARB, with no valid request: `we` registers 0, `sel`/`wd` hold their values, `rr_ptr` holds.
- `stall_cnt`:
  - Increments in any ARB cycle where popcount(`req_valid`) ≥ 2.
  - Saturates at 255; cleared only by `rst`.
- `clear`=1 in any state:
  - `req_ready` is forced to all 0 that cycle.
  - Next edge: state INIT, `cnt`=0, `init_done`=0, `we`=0.
  - The first clearing write (`sel`=0) registers on the following edge.
  - `clear` held high keeps restarting INIT at `cnt`=0.
  - `rr_ptr` is preserved across `clear`.
- Handshake rules:
  - A requester holds `req_valid`, `req_sel` and `req_wd` stable until it sees `req_ready`.
  - Dropping `req_valid` before the grant is allowed (request withdrawn).
  - The scheduler never grants a requester whose `req_valid` is 0.
- Same-register collisions: two requesters targeting the same `sel` are serialised in round-robin order; the later write wins in the bank.
- A single requester with continuous `req_valid` is granted every cycle when it is the only one valid (100% port utilisation).

## Timing
- Reset values: `sel`=0, `wd`=0, `we`=0, `init_done`=0, `stall_cnt`=0, `req_ready`=0.
- Internal reset state: state INIT, `cnt`=0, `rr_ptr`=0.
- Edges are counted after `rst` deasserts. Edges 1..8 present `we`=1, `wd`=0, `sel`=0..7 respectively.
- `init_done`=1 from edge 8.
- The first grant is possible in the cycle after edge 8.
- Request latency:
  - A request granted in cycle c appears on `sel`/`wd`/`we` after the edge ending c.
  - The bank register updates at the edge ending c+1.
  - Total: 2 edges from grant to stored value.
- Throughput: one write per cycle.
- Fairness: worst-case wait for a continuously valid requester is N-1 grants.
- `rst` asserted mid-operation: immediate asynchronous return to reset values; any in-flight `we` is dropped.
- `clear` and `req_valid` asserted in the same cycle: `clear` wins; no grant that cycle.

## Test plan
- Reset release with no requests:
  - Edges 1..8 show `we`=1, `sel`=0..7, `wd`=0.
  - `init_done`=1 at edge 8, then `we`=0.
  - All bank registers read 0.
- Requester 2 alone, `req_sel`=5, `req_wd`=8'hA5, after `init_done`:
  - `req_ready`=4'b0100 in the same cycle.
  - Next edge: `sel`=5, `wd`=A5, `we`=1.
  - The bank's register 5 reads A5 one edge later.
- All 4 valid continuously, requester i writing i+1 to register i:
  - Grants in order 0,1,2,3,0,…
  - `stall_cnt` increments each cycle and saturates at 255 after 255 cycles.
- Requesters 1 and 3 both target register 4, with data 11 and 33, `rr_ptr`=0:
  - Requester 1 is granted first, then 3.
  - Register 4 ends at 33.
- `clear` pulse while requester 0 is valid:
  - `req_ready`=0 that cycle, `init_done`=0 next edge.
  - Eight zeroing writes follow.
  - Requester 0, still holding valid, is granted after `init_done` returns to 1.
- `rst` asserted mid-INIT at `cnt`=4:
  - Outputs go to reset values asynchronously.
  - INIT restarts from `sel`=0 after release.
